// File: rtl/elevador_controle_n.sv
// SCAN elevator controller for NUM_ANDARES floors: latched calls, per-floor travel and door timing on tick.
// Outputs are registered; an overloaded cabin holds the door open and so never departs.
module elevador_controle_n #(
    parameter int NUM_ANDARES    = 4,
    parameter int ANDAR_W        = 2,
    parameter int TICKS_ANDAR    = 4,
    parameter int TICKS_PORTA    = 8,
    parameter int CAPACIDADE_W   = 4,
    parameter int CAPACIDADE_MAX = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [NUM_ANDARES-1:0]  chamada,
    input  logic [CAPACIDADE_W-1:0] capacidade_atual,
    output logic [ANDAR_W-1:0]      andar_atual,
    output logic [1:0]              direcao,
    output logic                    porta_aberta,
    output logic [NUM_ANDARES-1:0]  chamadas_pendentes,
    output logic                    sobrecarga
);

    localparam int CA_W = (TICKS_ANDAR > 1) ? $clog2(TICKS_ANDAR) : 1;
    localparam int CP_W = (TICKS_PORTA > 1) ? $clog2(TICKS_PORTA) : 1;
    localparam logic [CA_W-1:0] ULT_ANDAR = CA_W'(TICKS_ANDAR - 1);
    localparam logic [CP_W-1:0] ULT_PORTA = CP_W'(TICKS_PORTA - 1);
    localparam logic [NUM_ANDARES-1:0] UM = NUM_ANDARES'(1);

    typedef enum logic [1:0] {PARADO, SUBINDO, DESCENDO, PORTA} estado_t;

    estado_t              estado;
    logic [CA_W-1:0]      cnt_andar;
    logic [CP_W-1:0]      cnt_porta;

    logic [ANDAR_W-1:0]     andar_prox;
    logic [NUM_ANDARES-1:0] sel_atual, sel_prox, chamada_ok;
    logic                   reinicia, acima, abaixo, acima_prox, abaixo_prox, pend_aqui, pend_prox;

    function automatic logic tem_acima(input logic [NUM_ANDARES-1:0] p, input logic [ANDAR_W-1:0] a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_ANDARES; i++)
            if (p[i] && (i > int'(a))) r = 1'b1;
        return r;
    endfunction

    function automatic logic tem_abaixo(input logic [NUM_ANDARES-1:0] p, input logic [ANDAR_W-1:0] a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_ANDARES; i++)
            if (p[i] && (i < int'(a))) r = 1'b1;
        return r;
    endfunction

    // A call for the floor whose door is open is absorbed: it re-arms the door instead of latching.
    assign sel_atual   = UM << andar_atual;
    assign andar_prox  = (estado == DESCENDO) ? andar_atual - ANDAR_W'(1) : andar_atual + ANDAR_W'(1);
    assign sel_prox    = UM << andar_prox;
    assign chamada_ok  = (estado == PORTA) ? (chamada & ~sel_atual) : chamada;
    assign reinicia    = (estado == PORTA) && |(chamada & sel_atual);
    assign acima       = tem_acima(chamadas_pendentes, andar_atual);
    assign abaixo      = tem_abaixo(chamadas_pendentes, andar_atual);
    assign acima_prox  = tem_acima(chamadas_pendentes, andar_prox);
    assign abaixo_prox = tem_abaixo(chamadas_pendentes, andar_prox);
    assign pend_aqui   = |(chamadas_pendentes & sel_atual);
    assign pend_prox   = |(chamadas_pendentes & sel_prox);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado             <= PARADO;
            cnt_andar          <= '0;
            cnt_porta          <= '0;
            andar_atual        <= '0;
            direcao            <= 2'b00;
            porta_aberta       <= 1'b0;
            chamadas_pendentes <= '0;
            sobrecarga         <= 1'b0;
        end else begin
            sobrecarga         <= capacidade_atual > CAPACIDADE_W'(CAPACIDADE_MAX);
            chamadas_pendentes <= chamadas_pendentes | chamada_ok;
            case (estado)
                PARADO: if (tick) begin
                    if (pend_aqui) begin
                        estado             <= PORTA;
                        porta_aberta       <= 1'b1;
                        cnt_porta          <= '0;
                        chamadas_pendentes <= (chamadas_pendentes | chamada_ok) & ~sel_atual;
                    end else if (acima) begin
                        estado    <= SUBINDO;
                        direcao   <= 2'b01;
                        cnt_andar <= '0;
                    end else if (abaixo) begin
                        estado    <= DESCENDO;
                        direcao   <= 2'b10;
                        cnt_andar <= '0;
                    end
                end
                SUBINDO, DESCENDO: if (tick) begin
                    if (cnt_andar == ULT_ANDAR) begin
                        cnt_andar   <= '0;
                        andar_atual <= andar_prox;
                        // Only calls latched before this arrival edge can stop the cabin here.
                        if (pend_prox) begin
                            estado             <= PORTA;
                            porta_aberta       <= 1'b1;
                            cnt_porta          <= '0;
                            chamadas_pendentes <= (chamadas_pendentes | chamada_ok) & ~sel_prox;
                        end else if ((estado == SUBINDO) ? !acima_prox : !abaixo_prox) begin
                            estado  <= PARADO;
                            direcao <= 2'b00;
                        end
                    end else begin
                        cnt_andar <= cnt_andar + CA_W'(1);
                    end
                end
                PORTA: if (reinicia || sobrecarga) begin
                    cnt_porta <= '0;
                end else if (tick) begin
                    if (cnt_porta == ULT_PORTA) begin
                        cnt_porta    <= '0;
                        porta_aberta <= 1'b0;
                        cnt_andar    <= '0;
                        if (direcao == 2'b10) begin
                            if (abaixo)     estado <= DESCENDO;
                            else if (acima) begin estado <= SUBINDO; direcao <= 2'b01; end
                            else            begin estado <= PARADO;  direcao <= 2'b00; end
                        end else begin
                            if (acima)       begin estado <= SUBINDO;  direcao <= 2'b01; end
                            else if (abaixo) begin estado <= DESCENDO; direcao <= 2'b10; end
                            else             begin estado <= PARADO;   direcao <= 2'b00; end
                        end
                    end else begin
                        cnt_porta <= cnt_porta + CP_W'(1);
                    end
                end
                default: estado <= PARADO;
            endcase
        end
    end

endmodule

// File: tb/tb_elevador_controle_n.sv
// Bench for elevador_controle_n: directed table, corner-case sequences and random traffic against a floor-level model.
module tb_elevador_controle_n;

    localparam int N  = 4;
    localparam int TA = 2;
    localparam int TP = 3;
    localparam int CMAX = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] chamada = 4'b0;
    logic [3:0] capacidade_atual = 4'd0;
    logic [1:0] andar_atual;
    logic [1:0] direcao;
    logic       porta_aberta;
    logic [3:0] chamadas_pendentes;
    logic       sobrecarga;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: floor number, signed direction (-1/0/+1), progress in ticks, door timer.
    int       m_floor, m_prog, m_dcnt, m_dir;
    bit       m_door, m_moving, m_sob;
    bit [3:0] m_pend;

    elevador_controle_n #(
        .NUM_ANDARES(N), .ANDAR_W(2), .TICKS_ANDAR(TA), .TICKS_PORTA(TP),
        .CAPACIDADE_W(4), .CAPACIDADE_MAX(CMAX)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .chamada(chamada),
        .capacidade_atual(capacidade_atual), .andar_atual(andar_atual),
        .direcao(direcao), .porta_aberta(porta_aberta),
        .chamadas_pendentes(chamadas_pendentes), .sobrecarga(sobrecarga)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (reset) assert (andar_atual < N && direcao != 2'b11)
            else $error("FAIL range: andar=%0d direcao=%b", andar_atual, direcao);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit ahead(bit [3:0] p, int f, int d);
        for (int i = 0; i < N; i++)
            if (p[i] && (i - f) * d > 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] dir_bits(int d);
        return (d > 0) ? 2'b01 : (d < 0) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_prog = 0; m_dcnt = 0; m_dir = 0;
        m_door = 0; m_moving = 0; m_sob = 0; m_pend = 4'b0;
    endtask

    task automatic start_move(int d);
        m_moving = 1; m_dir = d; m_prog = 0;
    endtask

    task automatic model_step(input bit t, input bit [3:0] ch, input int cap);
        bit [3:0] p, np;
        int d;
        p  = m_pend;
        np = p | ch;
        if (m_door) begin
            np[m_floor] = 1'b0;
            if (ch[m_floor] || m_sob) m_dcnt = 0;
            else if (t) begin
                if (m_dcnt == TP - 1) begin
                    m_door = 0; m_dcnt = 0;
                    d = (m_dir == 0) ? 1 : m_dir;
                    if (ahead(p, m_floor, d))       start_move(d);
                    else if (ahead(p, m_floor, -d)) start_move(-d);
                    else                            m_dir = 0;
                end else m_dcnt++;
            end
        end else if (t && m_moving) begin
            m_prog++;
            if (m_prog == TA) begin
                m_prog = 0;
                m_floor += m_dir;
                if (p[m_floor]) begin
                    m_moving = 0; m_door = 1; m_dcnt = 0; np[m_floor] = 1'b0;
                end else if (!ahead(p, m_floor, m_dir)) begin
                    m_moving = 0; m_dir = 0;
                end
            end
        end else if (t) begin
            if (p[m_floor]) begin
                m_door = 1; m_dcnt = 0; m_dir = 0; np[m_floor] = 1'b0;
            end else if (ahead(p, m_floor, 1))  start_move(1);
            else if (ahead(p, m_floor, -1))     start_move(-1);
        end
        m_pend = np;
        m_sob  = cap > CMAX;
    endtask

    task automatic step(input logic t, input logic [3:0] ch, input int cap);
        tick = t; chamada = ch; capacidade_atual = 4'(cap);
        @(posedge clock);
        model_step(t, ch, cap);
        #1;
        chk("andar", 32'(andar_atual), 32'(m_floor));
        chk("direcao", 32'(direcao), 32'(dir_bits(m_dir)));
        chk("porta", 32'(porta_aberta), 32'(m_door));
        chk("pend", 32'(chamadas_pendentes), 32'(m_pend));
        chk("sobrecarga", 32'(sobrecarga), 32'(m_sob));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_andar", 32'(andar_atual), 0);
        chk("rst_direcao", 32'(direcao), 0);
        chk("rst_porta", 32'(porta_aberta), 0);
        chk("rst_pend", 32'(chamadas_pendentes), 0);
        chk("rst_sobrecarga", 32'(sobrecarga), 0);
        model_reset();
        tick = 1'b0; chamada = 4'b0; capacidade_atual = 4'd0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    typedef struct packed {
        logic [3:0] ch;
        logic [1:0] e_andar;
        logic [1:0] e_dir;
        logic       e_porta;
        logic [3:0] e_pend;
    } vec_t;

    vec_t tab [10];

    initial begin
        // Call to floor 2 from rest: two ticks per floor, door open three ticks.
        tab[0] = '{4'b0100, 2'd0, 2'b00, 1'b0, 4'b0100};
        tab[1] = '{4'b0000, 2'd0, 2'b01, 1'b0, 4'b0100};
        tab[2] = '{4'b0000, 2'd0, 2'b01, 1'b0, 4'b0100};
        tab[3] = '{4'b0000, 2'd1, 2'b01, 1'b0, 4'b0100};
        tab[4] = '{4'b0000, 2'd1, 2'b01, 1'b0, 4'b0100};
        tab[5] = '{4'b0000, 2'd2, 2'b01, 1'b1, 4'b0000};
        tab[6] = '{4'b0000, 2'd2, 2'b01, 1'b1, 4'b0000};
        tab[7] = '{4'b0000, 2'd2, 2'b01, 1'b1, 4'b0000};
        tab[8] = '{4'b0000, 2'd2, 2'b00, 1'b0, 4'b0000};
        tab[9] = '{4'b0000, 2'd2, 2'b00, 1'b0, 4'b0000};

        model_reset();
        #2;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tab[i].ch, 0);
            chk("tab_andar", 32'(andar_atual), 32'(tab[i].e_andar));
            chk("tab_dir", 32'(direcao), 32'(tab[i].e_dir));
            chk("tab_porta", 32'(porta_aberta), 32'(tab[i].e_porta));
            chk("tab_pend", 32'(chamadas_pendentes), 32'(tab[i].e_pend));
        end

        // Call for floor 1 placed while leaving floor 0 stops the cabin on the way to 3.
        do_reset();
        step(1, 4'b1000, 0);
        step(1, 4'b0010, 0);
        step(1, 4'b0000, 0);
        step(1, 4'b0000, 0);
        chk("pass_stop_andar", 32'(andar_atual), 1);
        chk("pass_stop_porta", 32'(porta_aberta), 1);
        for (int i = 0; i < 12; i++) step(1, 4'b0000, 0);
        chk("pass_end_andar", 32'(andar_atual), 3);
        chk("pass_end_dir", 32'(direcao), 0);
        chk("pass_end_pend", 32'(chamadas_pendentes), 0);

        // Overload holds the door; it closes three ticks after the flag clears.
        do_reset();
        step(1, 4'b0100, 9);
        for (int i = 0; i < 5; i++) step(1, 4'b0000, 9);
        chk("ovl_flag", 32'(sobrecarga), 1);
        for (int i = 0; i < 20; i++) begin
            step(1, 4'b0000, 9);
            chk("ovl_hold", 32'(porta_aberta), 1);
        end
        step(1, 4'b0000, 8);
        chk("ovl_clear", 32'(sobrecarga), 0);
        step(1, 4'b0000, 8);
        step(1, 4'b0000, 8);
        chk("ovl_still_open", 32'(porta_aberta), 1);
        step(1, 4'b0000, 8);
        chk("ovl_closed", 32'(porta_aberta), 0);

        // Serve floor 3 first, then reverse down to floor 0.
        do_reset();
        step(1, 4'b1000, 0);
        for (int i = 0; i < 3; i++) step(1, 4'b0000, 0);
        step(1, 4'b0001, 0);
        for (int i = 0; i < 6; i++) step(1, 4'b0000, 0);
        chk("rev_dir", 32'(direcao), 32'(2'b10));
        chk("rev_andar", 32'(andar_atual), 3);
        for (int i = 0; i < 11; i++) step(1, 4'b0000, 0);
        chk("rev_end_andar", 32'(andar_atual), 0);
        chk("rev_end_dir", 32'(direcao), 0);
        chk("rev_end_pend", 32'(chamadas_pendentes), 0);

        // Same-floor call while the door is open restarts the door timer.
        do_reset();
        step(1, 4'b0010, 0);
        for (int i = 0; i < 3; i++) step(1, 4'b0000, 0);
        chk("rst_door_open", 32'(porta_aberta), 1);
        step(1, 4'b0000, 0);
        step(1, 4'b0000, 0);
        step(1, 4'b0010, 0);
        chk("rst_door_hold", 32'(porta_aberta), 1);
        chk("rst_door_pend", 32'(chamadas_pendentes), 0);
        step(1, 4'b0000, 0);
        step(1, 4'b0000, 0);
        chk("rst_door_late", 32'(porta_aberta), 1);
        step(1, 4'b0000, 0);
        chk("rst_door_close", 32'(porta_aberta), 0);

        // tick low freezes travel; reset mid-travel clears everything at once.
        do_reset();
        step(1, 4'b1000, 0);
        for (int i = 0; i < 3; i++) step(1, 4'b0000, 0);
        for (int i = 0; i < 50; i++) step(0, 4'b0000, 0);
        chk("frz_andar", 32'(andar_atual), 1);
        chk("frz_dir", 32'(direcao), 32'(2'b01));
        step(1, 4'b0000, 0);
        step(1, 4'b0000, 0);
        chk("frz_resume", 32'(andar_atual), 2);
        do_reset();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] ch;
            int cap;
            ch = 4'b0;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 9) == 0) ch[b] = 1'b1;
            cap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            if ($urandom_range(0, 599) == 0) do_reset();
            else step($urandom_range(0, 2) != 0, ch, cap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
